// File: rtl/alt_vipitc121_timing_pkg.sv
// Shared widths, vertical region encoding and output bundle for the ITC timing generator.
// region_decode gives the vertical region a given line belongs to; it is used to seed the FSM on sclr.
package alt_vipitc121_timing_pkg;

    localparam int H_W = 14;
    localparam int V_W = 13;

    typedef enum logic [1:0] {
        V_ACTIVE = 2'd0,
        V_FRONT  = 2'd1,
        V_SYNC   = 2'd2,
        V_BACK   = 2'd3
    } v_region_t;

    // Active-high internal view of the outputs; polarity is applied only at the pins.
    typedef struct packed {
        logic sof;
        logic de;
        logic v_blank;
        logic h_blank;
        logic v_sync;
        logic h_sync;
    } timing_t;

    localparam timing_t TIMING_IDLE = '{sof: 1'b0, de: 1'b0, v_blank: 1'b1,
                                        h_blank: 1'b1, v_sync: 1'b0, h_sync: 1'b0};

    function automatic v_region_t region_decode(input logic [V_W-1:0] v,
                                                input logic [V_W-1:0] v_active,
                                                input logic [V_W-1:0] v_sync_start,
                                                input logic [V_W-1:0] v_sync_end);
        if ((v >= v_sync_start) && (v < v_sync_end))
            return V_SYNC;
        else if (v < v_active)
            return V_ACTIVE;
        else if ((v >= v_sync_end) && (v >= v_sync_start))
            return V_BACK;
        else
            return V_FRONT;
    endfunction

endpackage

// File: rtl/alt_vipitc121_common_delay_line.sv
// Generic N-stage, W-bit register delay line (N=0 is a wire); latency N cycles.
// Free-running every clock, no backpressure; async reset loads RST_VAL into every stage.
module alt_vipitc121_common_delay_line #(
    parameter int             N       = 1,
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (N == 0) begin : g_wire
            assign q = d;
        end else begin : g_regs
            logic [N-1:0][W-1:0] stg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stg <= {N{RST_VAL}};
                end else begin
                    stg[0] <= d;
                    for (int i = 1; i < N; i++)
                        stg[i] <= stg[i-1];
                end
            end

            assign q = stg[N-1];
        end
    endgenerate

endmodule

// File: rtl/alt_vipitc121_common_timing_generator.sv
// Raster timing decoder: sync/blank/de/sof from frame-counter position; latency 1+SYNC_PIPELINE cycles.
// No backpressure: outputs update on enable cycles and hold otherwise; sclr forces inactive outputs.
module alt_vipitc121_common_timing_generator
    import alt_vipitc121_timing_pkg::*;
#(
    parameter int TOTALS_MINUS_ONE = 0,
    parameter int SYNC_PIPELINE    = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sclr,
    input  logic           enable,
    input  logic           start_of_sample,
    input  logic           new_line,
    input  logic [H_W-1:0] h_count,
    input  logic [V_W-1:0] v_count,
    input  logic [V_W-1:0] v_reset,
    input  logic [H_W-1:0] h_active,
    input  logic [H_W-1:0] h_sync_start,
    input  logic [H_W-1:0] h_sync_end,
    input  logic [V_W-1:0] v_total,
    input  logic [V_W-1:0] v_active,
    input  logic [V_W-1:0] v_sync_start,
    input  logic [V_W-1:0] v_sync_end,
    input  logic           hs_pol,
    input  logic           vs_pol,
    output logic           h_sync,
    output logic           v_sync,
    output logic           h_blank,
    output logic           v_blank,
    output logic           de,
    output logic           sof
);

    logic [V_W-1:0] v_total_int;
    logic [V_W-1:0] next_v;
    v_region_t      state;
    v_region_t      state_nxt;
    timing_t        stage_d;
    timing_t        stage_q;
    timing_t        out_q;

    assign v_total_int = (TOTALS_MINUS_ONE != 0) ? v_total : v_total - V_W'(1);
    // Mirrors the frame counter wrap so the FSM steps in lockstep with it.
    assign next_v      = (v_count >= v_total_int) ? '0 : v_count + V_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= V_ACTIVE;
        else if (sclr)
            state <= region_decode(v_reset, v_active, v_sync_start, v_sync_end);
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (enable && new_line) begin
            if (next_v == '0)
                state_nxt = V_ACTIVE;
            else if (next_v == v_sync_end)
                state_nxt = V_BACK;
            else if (next_v == v_sync_start)
                state_nxt = V_SYNC;
            else if (next_v == v_active)
                state_nxt = V_FRONT;
        end
    end

    always_comb begin
        stage_d         = TIMING_IDLE;
        stage_d.h_blank = (h_count >= h_active);
        stage_d.h_sync  = (h_count >= h_sync_start) && (h_count < h_sync_end);
        stage_d.v_blank = (state != V_ACTIVE);
        stage_d.v_sync  = (state == V_SYNC);
        stage_d.de      = !stage_d.h_blank && !stage_d.v_blank;
        stage_d.sof     = (h_count == '0) && (v_count == '0) && start_of_sample && enable;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stage_q <= TIMING_IDLE;
        else if (sclr)
            stage_q <= TIMING_IDLE;
        else if (enable)
            stage_q <= stage_d;
        else
            stage_q.sof <= 1'b0;
    end

    alt_vipitc121_common_delay_line #(
        .N       (SYNC_PIPELINE),
        .W       ($bits(timing_t)),
        .RST_VAL (TIMING_IDLE)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (stage_q),
        .q   (out_q)
    );

    // Registers carry active-high sync so reset values stay constant; polarity is static config.
    assign h_sync  = out_q.h_sync ^ ~hs_pol;
    assign v_sync  = out_q.v_sync ^ ~vs_pol;
    assign h_blank = out_q.h_blank;
    assign v_blank = out_q.v_blank;
    assign de      = out_q.de;
    assign sof     = out_q.sof;

endmodule

// File: tb/tb_alt_vipitc121_common_timing_generator.sv
// Bench: frame-counter stimulus, arithmetic region model with latency pipe, per-cycle compare plus literal totals.
module tb_alt_vipitc121_common_timing_generator;

    localparam int SP = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclr = 1'b0;
    logic        enable = 1'b0;
    logic        start_of_sample = 1'b1;
    logic        new_line = 1'b0;
    logic [13:0] h_count = '0;
    logic [12:0] v_count = '0;
    logic [12:0] v_reset = '0;
    logic [13:0] h_active = 14'd10;
    logic [13:0] h_sync_start = 14'd12;
    logic [13:0] h_sync_end = 14'd15;
    logic [12:0] v_total = 13'd525;
    logic [12:0] v_active = 13'd480;
    logic [12:0] v_sync_start = 13'd490;
    logic [12:0] v_sync_end = 13'd492;
    logic        hs_pol = 1'b0;
    logic        vs_pol = 1'b0;
    logic        h_sync, v_sync, h_blank, v_blank, de, sof;

    alt_vipitc121_common_timing_generator #(
        .TOTALS_MINUS_ONE (0),
        .SYNC_PIPELINE    (SP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sclr            (sclr),
        .enable          (enable),
        .start_of_sample (start_of_sample),
        .new_line        (new_line),
        .h_count         (h_count),
        .v_count         (v_count),
        .v_reset         (v_reset),
        .h_active        (h_active),
        .h_sync_start    (h_sync_start),
        .h_sync_end      (h_sync_end),
        .v_total         (v_total),
        .v_active        (v_active),
        .v_sync_start    (v_sync_start),
        .v_sync_end      (v_sync_end),
        .hs_pol          (hs_pol),
        .vs_pol          (vs_pol),
        .h_sync          (h_sync),
        .v_sync          (v_sync),
        .h_blank         (h_blank),
        .v_blank         (v_blank),
        .de              (de),
        .sof             (sof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Expected active-high outputs of one captured sample, tagged with the sample's position.
    typedef struct packed {
        logic        hs, vs, hb, vb, de, sof, en;
        logic [13:0] h;
        logic [12:0] v;
    } exp_t;

    function automatic exp_t idle_exp();
        exp_t e;
        e    = '0;
        e.hb = 1'b1;
        e.vb = 1'b1;
        return e;
    endfunction

    // Line region follows directly from v_count ranges; horizontal from h_count ranges.
    function automatic exp_t model_sample();
        exp_t e;
        e     = '0;
        e.hb  = (h_count >= h_active);
        e.hs  = (h_count >= h_sync_start) && (h_count < h_sync_end);
        e.vb  = !(v_count < v_active);
        e.vs  = (v_count >= v_sync_start) && (v_count < v_sync_end);
        e.de  = !e.hb && !e.vb;
        e.sof = (h_count == 14'd0) && (v_count == 13'd0) && start_of_sample;
        e.en  = 1'b1;
        e.h   = h_count;
        e.v   = v_count;
        return e;
    endfunction

    exp_t m1;
    exp_t mp [SP];
    exp_t eo;
    assign eo = mp[SP-1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= idle_exp();
            for (int i = 0; i < SP; i++) mp[i] <= idle_exp();
        end else begin
            if (sclr)
                m1 <= idle_exp();
            else if (enable)
                m1 <= model_sample();
            else begin
                m1.sof <= 1'b0;
                m1.en  <= 1'b0;
            end
            mp[0] <= m1;
            for (int i = 1; i < SP; i++) mp[i] <= mp[i-1];
        end
    end

    logic       chk_on = 1'b0;
    logic [5:0] got_v, want_v;
    int de_cnt, hs_cnt, vs_lines, sof_cnt, sof_cyc, line0_de, line0_hs;
    logic snap_vs [0:524];
    logic snap_vb [0:524];

    always @(negedge clk) begin
        if (chk_on) begin
            got_v  = {h_sync, v_sync, h_blank, v_blank, de, sof};
            want_v = {eo.hs ^ ~hs_pol, eo.vs ^ ~vs_pol, eo.hb, eo.vb, eo.de, eo.sof};
            n_cmp++;
            if (got_v !== want_v) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d tag_h=%0d tag_v=%0d got=%b expected=%b (hs vs hb vb de sof)",
                         cyc, eo.h, eo.v, got_v, want_v);
            end
            if (sof === 1'b1) begin
                sof_cnt++;
                sof_cyc = cyc;
            end
            if (eo.en) begin
                if (de) de_cnt++;
                if (h_sync == hs_pol) hs_cnt++;
                if (eo.v == 13'd0) begin
                    if (de) line0_de++;
                    if (h_sync == hs_pol) line0_hs++;
                end
                if (eo.h == 14'd0) begin
                    if (v_sync == vs_pol) vs_lines++;
                    if (eo.v < 13'd525) begin
                        snap_vs[eo.v] = v_sync;
                        snap_vb[eo.v] = v_blank;
                    end
                end
            end
        end
    end

    // Frame counter behaviour: advances only on enabled cycles.
    int hc = 0, vc = 0, h_tot = 16, pres_cyc = 0;

    task automatic drive_cycles(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            enable   = toggle ? (i % 2 == 0) : 1'b1;
            h_count  = 14'(hc);
            v_count  = 13'(vc);
            new_line = (hc == h_tot - 1);
            if (enable && hc == 0 && vc == 0) pres_cyc = cyc;
            @(posedge clk);
            #1;
            if (enable) begin
                if (hc == h_tot - 1) begin
                    hc = 0;
                    vc = (vc >= int'(v_total) - 1) ? 0 : vc + 1;
                end else begin
                    hc++;
                end
            end
        end
    endtask

    task automatic drive_idle(input int n);
        enable = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_sclr(input int vr);
        v_reset  = 13'(vr);
        sclr     = 1'b1;
        enable   = 1'b1;
        new_line = 1'b0;
        @(posedge clk);
        #1;
        sclr = 1'b0;
        hc   = 0;
        vc   = vr;
    endtask

    task automatic clear_tallies();
        de_cnt = 0; hs_cnt = 0; vs_lines = 0; sof_cnt = 0; sof_cyc = 0;
        line0_de = 0; line0_hs = 0;
    endtask

    initial begin
        clear_tallies();
        #1;
        rst    = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_h_blank", int'(h_blank), 1);
        check("reset_v_blank", int'(v_blank), 1);
        check("reset_de", int'(de), 0);
        check("reset_sof", int'(sof), 0);
        check("reset_h_sync_inactive", int'(h_sync), 1);
        check("reset_v_sync_inactive", int'(v_sync), 1);
        rst = 1'b0;
        drive_idle(2);

        // Full-width line: 640 active samples, HS 656..751.
        h_tot = 800; h_active = 14'd640; h_sync_start = 14'd656; h_sync_end = 14'd752;
        do_sclr(0);
        clear_tallies();
        drive_cycles(1600, 1'b0);
        drive_idle(4);
        check("line0_de_count", line0_de, 640);
        check("line0_hs_low_count", line0_hs, 96);

        // Short lines, full 525-line frame from line 0.
        h_tot = 16; h_active = 14'd10; h_sync_start = 14'd12; h_sync_end = 14'd15;
        do_sclr(0);
        clear_tallies();
        drive_cycles(16 * 525, 1'b0);
        drive_idle(4);
        check("frame_de_count", de_cnt, 4800);
        check("frame_hs_count", hs_cnt, 1575);
        check("frame_vs_lines", vs_lines, 2);
        check("frame_sof_count", sof_cnt, 1);
        check("frame_sof_latency", sof_cyc - pres_cyc, 1 + SP);
        check("vs_line489", int'(snap_vs[489]), 1);
        check("vs_line490", int'(snap_vs[490]), 0);
        check("vs_line491", int'(snap_vs[491]), 0);
        check("vs_line492", int'(snap_vs[492]), 1);
        check("vb_line479", int'(snap_vb[479]), 0);
        check("vb_line480", int'(snap_vb[480]), 1);
        check("vb_line524", int'(snap_vb[524]), 1);

        // 50% enable across the 524->0 wrap: same per-frame totals.
        do_sclr(523);
        clear_tallies();
        drive_cycles(2 * 16 * 525, 1'b1);
        drive_idle(4);
        check("toggle_de_count", de_cnt, 4800);
        check("toggle_hs_count", hs_cnt, 1575);
        check("toggle_vs_lines", vs_lines, 2);
        check("toggle_sof_count", sof_cnt, 1);
        check("toggle_sof_latency", sof_cyc - pres_cyc, 1 + SP);

        // Seed mid-sync at line 491 with active-high polarities.
        hs_pol = 1'b1; vs_pol = 1'b1;
        do_sclr(491);
        drive_cycles(16 * 35, 1'b0);
        drive_idle(4);
        check("seed491_vs_active", int'(snap_vs[491]), 1);
        check("seed491_vb", int'(snap_vb[491]), 1);
        check("seed492_vs_inactive", int'(snap_vs[492]), 0);
        check("seed492_vb", int'(snap_vb[492]), 1);
        check("seed_wrap_line0_vb", int'(snap_vb[0]), 0);

        // Coincident v_active/v_sync_start, and an HS window that can never assert.
        hs_pol = 1'b0; vs_pol = 1'b0;
        v_sync_start = 13'd480; v_sync_end = 13'd482;
        h_sync_start = 14'd12; h_sync_end = 14'd5;
        do_sclr(470);
        clear_tallies();
        drive_cycles(16 * 15, 1'b0);
        drive_idle(4);
        check("coinc_vs_line479", int'(snap_vs[479]), 1);
        check("coinc_vb_line479", int'(snap_vb[479]), 0);
        check("coinc_vs_line480", int'(snap_vs[480]), 0);
        check("coinc_vb_line480", int'(snap_vb[480]), 1);
        check("coinc_vs_line482", int'(snap_vs[482]), 1);
        check("hs_never_count", hs_cnt, 0);

        // Async reset in the middle of line 100.
        v_sync_start = 13'd490; v_sync_end = 13'd492;
        h_sync_start = 14'd12; h_sync_end = 14'd15;
        do_sclr(100);
        drive_cycles(5, 1'b0);
        check("pre_rst_de", int'(de), 1);
        enable = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_de", int'(de), 0);
        check("rst_async_h_blank", int'(h_blank), 1);
        check("rst_async_v_blank", int'(v_blank), 1);
        check("rst_async_h_sync", int'(h_sync), 1);
        check("rst_async_v_sync", int'(v_sync), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_idle(5);
        check("post_rst_de_held", int'(de), 0);
        do_sclr(100);
        clear_tallies();
        drive_cycles(32, 1'b0);
        drive_idle(4);
        check("resync_de_count", de_cnt, 20);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
